sysbus_mem_responder: RTL and testbench

Memory-side responder for the system bus: accepts line-sized read and write requests from a bus initiator (the core's fetch unit and, later, the data side) and answers them from an internal backing store. Reads return one 64-byte line as eight 64-bit beats, low address first, under a respcyc/respack handshake. Writes take eight data beats and return one completion beat. The block sits on the bus as the simulation memory model and as the functional reference for the real memory controller.

---
 rtl/sysbus_mem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sysbus_mem_responder
// Purpose  : Memory-side system-bus responder. It accepts line-sized (64-byte)
//            read and write requests and answers them from an internal
//            backing store of DEPTH_LINES*8 64-bit words.
//            A read returns eight 64-bit beats, low word first.
//            A write takes eight data beats and returns one zero completion beat.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH_LINES : number of 64-byte lines in the backing store
//   LATENCY     : cycles from the end of reqack to the first response beat (1..255)
// Ports
//   clk      in   1   bus clock, all state on posedge
//   reset_n  in   1   asynchronous active-low reset
//   reqcyc   in   1   request valid; also qualifies each write data beat
//   req      in  64   address (address cycle) / write data (data beats)
//   reqtag   in  13   [12] 1=read 0=write, [11:8] type (MEMORY=4'h1), [7:0] id
//   reqack   out  1   one-cycle acceptance pulse
//   respcyc  out  1   response beat valid
//   resp     out 64   response data
//   resptag  out 13   echo of the accepted reqtag
//   respack  in   1   initiator accepts the current beat
// Optional build macro
//   SYSBUS_MEM_ASSERT_EN : enables protocol checks that stop simulation
//                          with $fatal
// ============================================================================
module sysbus_mem_responder #(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack
);

  localparam int         LINE_W      = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int         IDX_W       = LINE_W + 3;
  localparam logic [3:0] TYPE_MEMORY = 4'h1;
  localparam logic [7:0] WAIT_LOAD   = 8'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK   = 3'd1,
    S_WDATA = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          beat_q,  beat_d;
  logic [7:0]          cnt_q,   cnt_d;
  logic [LINE_W-1:0]   line_q,  line_d;
  logic [12:0]         tag_q,   tag_d;
  logic                oor_q,   oor_d;   // captured line lies beyond the store
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;

  // Backing store: deliberately outside the reset domain so that written data
  // survives a reset_n pulse.
  logic [63:0] mem [0:DEPTH_LINES*8-1];

  assign mem_idx = {line_q, beat_q};
  assign resptag = tag_q;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    tag_d   = tag_q;
    oor_d   = oor_q;
    mem_we  = 1'b0;
    reqack  = 1'b0;
    respcyc = 1'b0;
    resp    = 64'd0;

    case (state_q)
      S_IDLE: begin
        // Only MEMORY-type requests are taken; anything else is dropped here.
        if (reqcyc && (reqtag[11:8] == TYPE_MEMORY)) begin
          line_d  = req[6 +: LINE_W];
          oor_d   = (req[63:6] >= 58'(DEPTH_LINES));
          tag_d   = reqtag;
          beat_d  = 3'd0;
          cnt_d   = 8'd0;
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        reqack = 1'b1;
        beat_d = 3'd0;
        if (tag_q[12]) begin
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_WDATA;
        end
      end

      S_WDATA: begin
        // Cycles with reqcyc low are bubbles and do not advance the beat.
        if (reqcyc) begin
          mem_we = !oor_q;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          beat_d  = 3'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_RESP: begin
        respcyc = 1'b1;
        // Write completion carries zero data; reads beyond the store read ones.
        if (tag_q[12]) begin
          resp = oor_q ? {64{1'b1}} : mem[mem_idx];
        end
        if (respack) begin
          if (!tag_q[12] || (beat_q == 3'd7)) begin
            beat_d  = 3'd0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      beat_q  <= 3'd0;
      cnt_q   <= 8'd0;
      line_q  <= '0;
      tag_q   <= 13'd0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      oor_q   <= oor_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= req;
    end
  end

`ifdef SYSBUS_MEM_ASSERT_EN
  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  generate
    if ((LATENCY < 1) || (LATENCY > 255)) begin : g_latency_bad
      $fatal(1, "sysbus_mem_responder: LATENCY=%0d outside 1..255", LATENCY);
    end
  endgenerate

  always @(posedge clk) begin
    if (reset_n) begin
      if ((state_q == S_IDLE) && reqcyc && (reqtag[11:8] != TYPE_MEMORY)) begin
        $fatal(1, "sysbus_mem_responder: unsupported request type %h", reqtag[11:8]);
      end
      if (respack && !respcyc) begin
        $fatal(1, "sysbus_mem_responder: respack high while respcyc low");
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysbus_mem_responder
// Purpose  : Directed self-checking bench for sysbus_mem_responder
//            (DEPTH_LINES=1024, LATENCY=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysbus_mem_responder;

  localparam int DEPTH_LINES = 1024;
  localparam int LATENCY     = 4;

  logic        clk;
  logic        reset_n;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;
  logic        ack_en;

  int errors;
  int checks;
  logic [63:0] exp_data [8];
  logic [63:0] wr_data  [8];

  // respack only ever accompanies a valid beat; ack_en lets the bench stall.
  assign respack = respcyc & ack_en;

  sysbus_mem_responder #(
    .DEPTH_LINES (DEPTH_LINES),
    .LATENCY     (LATENCY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .reqcyc  (reqcyc),
    .req     (req),
    .reqtag  (reqtag),
    .reqack  (reqack),
    .respcyc (respcyc),
    .resp    (resp),
    .resptag (resptag),
    .respack (respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Returns at the negedge after the ACK cycle.
  task automatic send_req(input logic [63:0] a, input logic [12:0] t, input bit hold);
    @(negedge clk);
    reqcyc = 1'b1;
    req    = a;
    reqtag = t;
    @(negedge clk);
    chk("reqack_pulse", reqack, 1);
    if (!hold) reqcyc = 1'b0;
    @(negedge clk);
    chk("reqack_single", reqack, 0);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!respcyc && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic write_line(input logic [63:0] a, input logic [12:0] t, input int gap);
    int lat;
    send_req(a, t, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == gap) begin
        reqcyc = 1'b0;
        @(negedge clk);
      end
      reqcyc = 1'b1;
      req    = wr_data[i];
      @(negedge clk);
    end
    reqcyc = 1'b0;
    wait_resp(lat);
    chk("wr_resp_valid", respcyc, 1);
    chk("wr_latency", 64'(lat), 64'(LATENCY));
    chk("wr_resp_zero", resp, 64'd0);
    chk("wr_resptag", resptag, t);
    @(negedge clk);
    chk("wr_single_beat", respcyc, 0);
  endtask

  task automatic read_line(input logic [63:0] a, input logic [12:0] t,
                           input int stall_beat, input int abort_beat);
    int lat;
    send_req(a, t, 1'b0);
    wait_resp(lat);
    chk("rd_resp_valid", respcyc, 1);
    chk("rd_latency", 64'(lat), 64'(LATENCY));
    for (int i = 0; i < 8; i++) begin
      chk("rd_beat_valid", respcyc, 1);
      chk("rd_beat_data", resp, exp_data[i]);
      chk("rd_resptag", resptag, t);
      if (i == abort_beat) begin
        ack_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_respcyc", respcyc, 0);
        chk("rst_async_reqack", reqack, 0);
        chk("rst_async_resp", resp, 64'd0);
        chk("rst_async_resptag", resptag, 13'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        return;
      end
      if (i == stall_beat) begin
        ack_en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_respcyc", respcyc, 1);
          chk("stall_data", resp, exp_data[i]);
        end
        ack_en = 1'b1;
      end
      @(negedge clk);
    end
    chk("rd_done", respcyc, 0);
  endtask

  task automatic count_beats(output int acks, output int beats);
    acks  = 0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      @(negedge clk);
      if (reqack) acks++;
      if (respcyc) begin
        chk("hold_beat_data", resp, exp_data[beats]);
        beats++;
      end
    end
  endtask

  initial begin
    int acks;
    int beats;
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    reqcyc  = 1'b0;
    req     = 64'd0;
    reqtag  = 13'd0;
    ack_en  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_reqack", reqack, 0);
    chk("reset_respcyc", respcyc, 0);
    chk("reset_resp", resp, 64'd0);
    chk("reset_resptag", resptag, 13'd0);
    reset_n = 1'b1;

    // Line 0 gets a known pattern so it can be checked after the out-of-range write.
    for (int i = 0; i < 8; i++) wr_data[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    write_line(64'h0, 13'h0101, -1);

    // Write line 1 (addr 0x40) with a bubble before beat 3.
    for (int i = 0; i < 8; i++) wr_data[i] = 64'h11 * 64'(i + 1);
    write_line(64'h40, 13'h0105, 3);

    // Read it back, aligned and unaligned.
    for (int i = 0; i < 8; i++) exp_data[i] = 64'h11 * 64'(i + 1);
    read_line(64'h40, 13'h1107, -1, -1);
    read_line(64'h47, 13'h1108, -1, -1);

    // Stall beat 2 for three cycles.
    read_line(64'h40, 13'h1109, 2, -1);

    // Unsupported type is ignored.
    @(negedge clk);
    reqcyc = 1'b1;
    req    = 64'h40;
    reqtag = 13'h1207;
    @(negedge clk);
    chk("badtype_no_ack", reqack, 0);
    reqcyc = 1'b0;
    repeat (6) @(negedge clk);
    chk("badtype_no_resp", respcyc, 0);

    // Out-of-range line: reads all-ones, writes dropped.
    for (int i = 0; i < 8; i++) exp_data[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    read_line(64'(DEPTH_LINES) * 64, 13'h110A, -1, -1);
    for (int i = 0; i < 8; i++) wr_data[i] = 64'hAA;
    write_line(64'(DEPTH_LINES) * 64, 13'h010B, -1);
    for (int i = 0; i < 8; i++) exp_data[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    read_line(64'h0, 13'h110C, -1, -1);

    // Reset during beat 4, then a full clean read.
    for (int i = 0; i < 8; i++) exp_data[i] = 64'h11 * 64'(i + 1);
    read_line(64'h40, 13'h110D, -1, 4);
    @(negedge clk);
    chk("post_rst_idle", respcyc, 0);
    read_line(64'h40, 13'h110E, -1, -1);

    // reqcyc held high through the whole read.
    send_req(64'h40, 13'h110F, 1'b1);
    count_beats(acks, beats);
    chk("hold_no_extra_ack", 64'(acks), 64'd0);
    chk("hold_beat_count", 64'(beats), 64'd8);
    @(negedge clk);
    chk("hold_idle_respcyc", respcyc, 0);
    chk("hold_idle_reqack", reqack, 0);
    @(negedge clk);
    chk("hold_second_ack", reqack, 1);
    reqcyc = 1'b0;
    count_beats(acks, beats);
    chk("hold2_beat_count", 64'(beats), 64'd8);
    @(negedge clk);
    chk("hold2_done", respcyc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
